// File: rtl/sipo_deser_pkg.sv
// Shared types for the serial-in/parallel-out deserialiser.
// The PARITY state is only reachable when SIPO_DESER_PARITY_EN is defined.
package sipo_deser_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit shift register; shift direction is chosen at elaboration.
// word_o shows the word including the current input bit unless hold_i is set.
module sipo_shift_core #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             hold_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] word_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] shifted;

  // MSB-first enters at bit 0 and moves up; LSB-first enters at the top and moves down
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (MSB_FIRST != 0) begin : g_msb
      if (gi == 0) begin : g_in
        assign shifted[gi] = d_i;
      end else begin : g_mid
        assign shifted[gi] = sr_q[gi-1];
      end
    end else begin : g_lsb
      if (gi == WIDTH - 1) begin : g_in
        assign shifted[gi] = d_i;
      end else begin : g_mid
        assign shifted[gi] = sr_q[gi+1];
      end
    end
  end

  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (en_i) begin
      sr_d = shifted;
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign word_o = hold_i ? sr_q : shifted;

endmodule

// File: rtl/sipo_deser.sv
// Deserialiser with a one-word holding register and valid/ready handshake.
// Define SIPO_DESER_PARITY_EN to append an even-parity bit to every frame.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  input  logic             d_valid,
  input  logic             clr,
  input  logic             q_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int              CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             overrun_q, overrun_d;
  logic             shift_en;
  logic             complete;
  logic [WIDTH-1:0] word;

  sipo_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk   (clk),
    .clr_i (reset | clr),
    .en_i  (shift_en),
    .hold_i(state_q == PARITY),
    .d_i   (d),
    .word_o(word)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_en  = 1'b0;
    complete  = 1'b0;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    overrun_d = 1'b0;

    if (clr) begin
      state_d = COLLECT;
      cnt_d   = '0;
    end else if (d_valid) begin
      if (state_q == PARITY) begin
        // Parity bit closes the frame; the data bits are already stored
        state_d  = COLLECT;
        complete = 1'b1;
      end else begin
        shift_en = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d = '0;
`ifdef SIPO_DESER_PARITY_EN
          state_d = PARITY;
`else
          complete = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    if (complete) begin
      if (!q_valid_q || q_ready) begin
        q_d       = word;
        q_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (q_valid_q && q_ready) begin
      q_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SIPO_DESER_PARITY_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (complete && (!q_valid_q || q_ready)) begin
      perr_d = (^word) ^ d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign overrun = overrun_q;
  assign busy    = (cnt_q != '0) || (state_q == PARITY);

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser (WIDTH=4), one MSB-first and one LSB-first instance.
// Honours SIPO_DESER_PARITY_EN so it can be built with or without the parity frame bit.
module tb_sipo_deser;

`ifdef SIPO_DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int FL     = 5;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int FL     = 4;
`endif

  logic       clk = 1'b0;
  logic       reset, d, d_valid, clr, q_ready;
  logic [3:0] q_m, q_l;
  logic       qv_m, qv_l, busy_m, busy_l, ov_m, ov_l, perr_m, perr_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .clr(clr), .q_ready(q_ready),
    .q(q_m), .q_valid(qv_m), .busy(busy_m), .overrun(ov_m), .parity_err(perr_m)
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .clr(clr), .q_ready(q_ready),
    .q(q_l), .q_valid(qv_l), .busy(busy_l), .overrun(ov_l), .parity_err(perr_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bits of the current frame are kept in a queue and the
  // word is built from bit positions once the frame length is reached.
  bit         frame[$];
  logic [3:0] exp_qm, exp_ql;
  bit         exp_qv, exp_ov, exp_perr, exp_busy;
  bit         model_live = 1'b0;

  always @(posedge clk) begin : model
    bit         done;
    bit         par;
    logic [3:0] wm, wl;
    done = 1'b0;
    par  = 1'b0;
    wm   = '0;
    wl   = '0;
    if (reset) begin
      frame.delete();
      exp_qm     = '0;
      exp_ql     = '0;
      exp_qv     = 1'b0;
      exp_ov     = 1'b0;
      exp_perr   = 1'b0;
      model_live = 1'b1;
    end else begin
      exp_ov = 1'b0;
      if (clr) begin
        frame.delete();
      end else if (d_valid) begin
        frame.push_back(d);
        if (frame.size() == FL) begin
          done = 1'b1;
          foreach (frame[i]) par ^= frame[i];
          for (int i = 0; i < 4; i++) begin
            wm[3-i] = frame[i];
            wl[i]   = frame[i];
          end
          frame.delete();
        end
      end
      if (done) begin
        if (!exp_qv || q_ready) begin
          exp_qm   = wm;
          exp_ql   = wl;
          exp_qv   = 1'b1;
          exp_perr = PAR_EN ? par : 1'b0;
        end else begin
          exp_ov = 1'b1;
        end
      end else if (exp_qv && q_ready) begin
        exp_qv = 1'b0;
      end
    end
    exp_busy = (frame.size() != 0);
  end

  always @(negedge clk) begin : compare
    if (model_live) begin
      check("q_msb", q_m, exp_qm);
      check("q_lsb", q_l, exp_ql);
      check("q_valid_msb", qv_m, exp_qv);
      check("q_valid_lsb", qv_l, exp_qv);
      check("busy_msb", busy_m, exp_busy);
      check("busy_lsb", busy_l, exp_busy);
      check("overrun_msb", ov_m, exp_ov);
      check("overrun_lsb", ov_l, exp_ov);
      if (exp_qv) begin
        check("parity_err_msb", perr_m, exp_perr);
        check("parity_err_lsb", perr_l, exp_perr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic dv, input logic db, input logic cl);
    tick();
    d_valid = dv;
    d       = db;
    clr     = cl;
  endtask

  // Sends w[3] first; the parity bit p follows only in parity builds
  task automatic send_word(input logic [3:0] w, input logic p);
    for (int i = 3; i >= 0; i--) drive(1'b1, w[i], 1'b0);
    if (PAR_EN) drive(1'b1, p, 1'b0);
  endtask

  task automatic settle();
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    d       = 1'b0;
    d_valid = 1'b0;
    clr     = 1'b0;
    q_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    $display("txn: reset");
    check("lit_reset_q", q_m, 4'h0);
    check("lit_reset_qv", qv_m, 1'b0);
    check("lit_reset_busy", busy_m, 1'b0);
    check("lit_reset_ov", ov_l, 1'b0);

    send_word(4'b1001, 1'b0);
    settle();
    $display("txn: word 1,0,0,1");
    check("lit_w1_q_msb", q_m, 4'b1001);
    check("lit_w1_qv_msb", qv_m, 1'b1);
    check("lit_w1_busy", busy_m, 1'b0);
    check("lit_w1_q_lsb", q_l, 4'b1001);

    send_word(4'b1001, 1'b0);
    send_word(4'b1100, 1'b0);
    settle();
    $display("txn: words 1,0,0,1 then 1,1,0,0");
    check("lit_w2_q_lsb", q_l, 4'b0011);
    check("lit_w2_q_msb", q_m, 4'b1100);
    check("lit_w2_qv_lsb", qv_l, 1'b1);

    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    if (PAR_EN) drive(1'b1, 1'b0, 1'b0);
    settle();
    $display("txn: gapped word 0,1,1,0");
    check("lit_gap_q_msb", q_m, 4'b0110);
    check("lit_gap_q_lsb", q_l, 4'b0110);

    repeat (2) drive(1'b0, 1'b0, 1'b0);
    q_ready = 1'b0;
    send_word(4'b1010, 1'b0);
    settle();
    $display("txn: held word 1,0,1,0");
    check("lit_hold_q_msb", q_m, 4'b1010);
    check("lit_hold_qv", qv_m, 1'b1);
    send_word(4'b0011, 1'b0);
    settle();
    $display("txn: dropped word 0,0,1,1");
    check("lit_ovr_pulse", ov_m, 1'b1);
    check("lit_ovr_q_kept", q_m, 4'b1010);
    check("lit_ovr_qv", qv_m, 1'b1);
    @(negedge clk);
    check("lit_ovr_one_cycle", ov_m, 1'b0);
    q_ready = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 1'b0);

    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("txn: clr after 2 bits");
    check("lit_clr_busy", busy_m, 1'b0);
    send_word(4'b1111, 1'b1);
    settle();
    $display("txn: word 1,1,1,1 after clr");
    check("lit_clr_q_msb", q_m, 4'b1111);
    check("lit_clr_q_lsb", q_l, 4'b1111);

    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    d_valid = 1'b0;
    @(negedge clk);
    $display("txn: reset after 2 bits");
    check("lit_rst_busy", busy_m, 1'b0);
    check("lit_rst_qv", qv_m, 1'b0);
    check("lit_rst_q", q_l, 4'h0);
    send_word(4'b0101, 1'b0);
    settle();
    $display("txn: clean word 0,1,0,1");
    check("lit_rst_q_msb", q_m, 4'b0101);
    check("lit_rst_q_lsb", q_l, 4'b1010);

    send_word(4'b1011, 1'b1);
    settle();
    $display("txn: word 1,0,1,1 with good parity");
    check("lit_par_ok_qv", qv_m, 1'b1);
    check("lit_par_ok_err", perr_m, 1'b0);
    send_word(4'b1011, 1'b0);
    settle();
    $display("txn: word 1,0,1,1 with bad parity");
    check("lit_par_bad_qv", qv_m, 1'b1);
    check("lit_par_bad_err", perr_m, PAR_EN);

    repeat (3) drive(1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the deserialised word width (WIDTH >= 2).
REQ-002 SHALL have parameter MSB_FIRST, default 1, where 1 means the first received bit lands in q[WIDTH-1] and 0 means it lands in q[0].
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port d, input, 1 bit: serial data bit.
REQ-006 SHALL have port d_valid, input, 1 bit: d is sampled only in cycles where this is high.
REQ-007 SHALL have port clr, input, 1 bit: framing resync, which discards the partial word.
REQ-008 SHALL have port q, output, WIDTH bits: the last completed word (holding register).
REQ-009 SHALL have port q_valid, output, 1 bit: q holds an unconsumed word.
REQ-010 SHALL have port q_ready, input, 1 bit: the consumer accepts q when q_valid and q_ready are both high.
REQ-011 SHALL have port busy, output, 1 bit: high when the partial word holds at least one bit.
REQ-012 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed word is dropped.
REQ-013 SHALL have port parity_err, output, 1 bit: parity status of q, valid while q_valid is high.

Function
REQ-014 SHALL shift d into an internal shift register and increment a bit counter (0..WIDTH-1) on each cycle where d_valid=1 and clr=0.
REQ-015 SHALL treat the word as complete on the cycle the WIDTH-th bit is sampled, reset the counter to 0 on that cycle, and start the next word on the following d_valid.
REQ-016 SHALL, on completion with q_valid=0 or q_ready=1, load q with the assembled word and set q_valid=1 on the next cycle (latency: 1 cycle after the last bit).
REQ-017 SHALL, on completion with q_valid=1 and q_ready=0, drop the new word, keep q unchanged, and pulse overrun for exactly one cycle.
REQ-018 SHALL clear q_valid after a cycle where q_valid=1, q_ready=1, and there is no simultaneous completion; q SHALL keep its value.
REQ-019 SHALL keep d_valid=0 cycles transparent: no shift, no count change.
REQ-020 SHALL give clr priority over d_valid: counter=0 and partial word discarded; q, q_valid and the handshake are unaffected.
REQ-021 SHALL implement the FSM with states COLLECT and, with the macro defined, PARITY. COLLECT goes to PARITY on the WIDTH-th bit; PARITY goes to COLLECT on the next d_valid.
REQ-022 SHALL drive busy as (counter != 0) or (state == PARITY).

Reset
REQ-023 SHALL, while reset=1, force q=0, q_valid=0, overrun=0, parity_err=0, busy=0, counter=0, state=COLLECT, and the shift register to 0.
REQ-024 SHALL give reset priority over clr, d_valid and q_ready, and SHALL discard any mid-word bits.

Configuration
REQ-025 SHALL use the macro SIPO_DESER_PARITY_EN.
REQ-026 With the macro defined, a frame SHALL be WIDTH data bits followed by one even-parity bit. Completion and the REQ-016/017 handling SHALL occur on the parity bit. parity_err SHALL be loaded with q as (XOR of data bits) XOR (parity bit).
REQ-027 With the macro undefined, frames SHALL be WIDTH bits, the PARITY state SHALL NOT exist, and parity_err SHALL be tied to 0.

Structure
REQ-028 SHALL place the state enum (COLLECT, PARITY) and a counter-width helper ($clog2(WIDTH)) in package sipo_deser_pkg.
REQ-029 SHALL use one sub-module, sipo_shift_core: a WIDTH-bit direction-selectable shift register with enable and clear. The handshake, FSM and counter SHALL stay in sipo_deser.

Verification (WIDTH=4)
REQ-030 With MSB_FIRST=1, driving d_valid high for bits 1,0,0,1 SHALL give q=4'b1001, q_valid=1 one cycle after the 4th bit, and busy=0.
REQ-031 With MSB_FIRST=0, the same bits 1,0,0,1 followed by 1,1,0,0 with q_ready=1 SHALL give q=4'b1001 and then q=4'b0011, with q_valid staying 1 across the back-to-back loads.
REQ-032 With q_ready=0, sending two full words SHALL keep q equal to the first word, pulse overrun once on the second completion, and keep q_valid=1.
REQ-033 Sending 2 bits, asserting clr, then sending 1,1,1,1 SHALL give q=4'b1111; asserting reset after 2 bits SHALL give busy=0, q_valid=0, and the next 4 bits SHALL form a clean word.
REQ-034 With the macro defined, sending 1,0,1,1 with parity bit 1 SHALL give q_valid=1 and parity_err=0; with parity bit 0, q_valid=1 and parity_err=1.
